// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-cycle shift-add multiply or restoring
// divide over operand magnitudes, sign fixup, then hold the result until writeback takes it.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_in_i,
    input  logic            flush_i,
    input  logic            wb_accept_i,
    output logic            busy_o,
    output logic            stall_req_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_out_o
);

    localparam int unsigned CW = 6;
    localparam int unsigned DW = 2 * XLEN;
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] XMIN      = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_ITER,
        S_DIV_ITER,
        S_FIXUP,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] hi_q, hi_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier-product low half / dividend-quotient
    logic [XLEN-1:0] m_q, m_d;       // multiplicand / divisor magnitude
    logic            neg_q, neg_d;   // product or quotient negative
    logic            rneg_q, rneg_d; // remainder negative (dividend sign)
    logic [XLEN-1:0] res_q, res_d;
    logic            busy_q, valid_q;

    // Operand signedness and magnitudes seen at the accept edge
    logic            sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        sgn_a    = funct3_i[2] ? !funct3_i[0] : !(funct3_i[1] & funct3_i[0]);
        sgn_b    = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
        neg_a    = sgn_a & rs1_i[XLEN-1];
        neg_b    = sgn_b & rs2_i[XLEN-1];
        mag_a    = neg_a ? (~rs1_i + XLEN'(1)) : rs1_i;
        mag_b    = neg_b ? (~rs2_i + XLEN'(1)) : rs2_i;
        div_zero = (rs2_i == '0);
        div_ovf  = !funct3_i[0] && (rs1_i == XMIN) && (rs2_i == '1);
    end

    logic [XLEN:0]   mul_sum, div_trial;
    logic [DW-1:0]   prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, m_q};
        prod      = {hi_q, lo_q};
        prod_fix  = neg_q ? (~prod + DW'(1)) : prod;
        quo_fix   = neg_q ? (~lo_q + XLEN'(1)) : lo_q;
        rem_fix   = rneg_q ? (~hi_q + XLEN'(1)) : hi_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d   = funct3_i;
                    rd_d   = rd_in_i;
                    hi_d   = '0;
                    lo_d   = mag_a;
                    m_d    = mag_b;
                    neg_d  = neg_a ^ neg_b;
                    rneg_d = neg_a;
                    cnt_d  = '0;
                    if (!funct3_i[2]) begin
                        state_d = S_MUL_ITER;
                    end else if (div_zero) begin
                        res_d   = funct3_i[1] ? rs1_i : '1;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        res_d   = funct3_i[1] ? '0 : XMIN;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV_ITER;
                    end
                end
            end
            S_MUL_ITER: begin
                {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = S_FIXUP;
            end
            S_DIV_ITER: begin
                if (!div_trial[XLEN]) begin
                    hi_d = div_trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                if (!op_q[2]) begin
                    res_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[DW-1:XLEN];
                end else begin
                    res_d = op_q[1] ? rem_fix : quo_fix;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (wb_accept_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
            busy_q  <= (state_d != S_IDLE);
            valid_q <= (state_d == S_DONE);
        end
    end

    assign stall_req_o    = ((state_q == S_IDLE) && start_i && !flush_i) ||
                            ((state_q != S_IDLE) && !((state_q == S_DONE) && wb_accept_i));
    assign busy_o         = busy_q;
    assign result_valid_o = valid_q;
    assign result_o       = res_q;
    assign rd_out_o       = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic RV32M model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_in;
    logic        flush, wb_accept;
    logic        busy, stall, valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .funct3_i      (funct3),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .rd_in_i       (rd_in),
        .flush_i       (flush),
        .wb_accept_i   (wb_accept),
        .busy_o        (busy),
        .stall_req_o   (stall),
        .result_valid_o(valid),
        .result_o      (result),
        .rd_out_o      (rd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Entered just after a falling edge; runs one operation through writeback.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit flush_at_wb);
        logic [31:0] exp_res, held;
        logic [4:0]  exp_rd;
        int          exp_lat, cyc;
        exp_res = ref_op(f, a, b);
        exp_lat = ref_latency(f, a, b);
        exp_rd  = 5'($urandom);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_in = exp_rd;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_at_accept f=%0d got %b want 1", f, stall); end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
        cyc = 1;
        while (valid !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc != exp_lat) begin n_fail++; $display("FAIL latency f=%0d a=%h b=%h got %0d want %0d", f, a, b, cyc, exp_lat); end
        n_tests++;
        if (result !== exp_res) begin n_fail++; $display("FAIL result f=%0d a=%h b=%h got %h want %h", f, a, b, result, exp_res); end
        n_tests++;
        if (rd_out !== exp_rd || busy !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL done_state rd=%0d busy=%b stall=%b want rd=%0d busy=1 stall=1", rd_out, busy, stall, exp_rd);
        end
        held = exp_res;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_tests++;
            if (result !== held || valid !== 1'b1 || stall !== 1'b1) begin
                n_fail++; $display("FAIL hold cycle %0d result=%h valid=%b stall=%b want %h 1 1", i, result, valid, stall, held);
            end
        end
        wb_accept = 1'b1; flush = flush_at_wb;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b want 0", stall); end
        @(negedge clk);
        wb_accept = 1'b0; flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_wb busy=%b valid=%b want 0 0", busy, valid); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_in = '0; flush = 1'b0; wb_accept = 1'b0;
        #1;
        n_tests++;
        if ({busy, stall, valid, result, rd_out} !== '0) begin
            n_fail++; $display("FAIL reset_values busy=%b stall=%b valid=%b result=%h rd=%0d want all 0", busy, stall, valid, result, rd_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul_basic;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5, 1'b0);
    endtask

    task automatic test_mulh_variants;
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    endtask

    task automatic test_div_signs;
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_op(3'd5, 32'd100, 32'd7, 1, 1'b0);
        do_op(3'd7, 32'd100, 32'd7, 0, 1'b0);
    endtask

    task automatic test_div_special;
        do_op(3'd5, 32'h1234, 32'd0, 0, 1'b0);
        do_op(3'd6, 32'h1234, 32'd0, 0, 1'b0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
    endtask

    task automatic test_flush;
        int cyc;
        bit saw;
        start = 1'b1; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; saw = 1'b0;
        while (cyc < 10) begin
            saw |= (valid === 1'b1);
            @(negedge clk);
            cyc++;
        end
        saw |= (valid === 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || valid !== 1'b0 || stall !== 1'b0 || saw) begin
            n_fail++; $display("FAIL flush_abort busy=%b valid=%b stall=%b saw_valid=%b want 0 0 0 0", busy, valid, stall, saw);
        end
        do_op(3'd0, 32'h0001_2345, 32'h0000_0ABC, 0, 1'b0);
    endtask

    task automatic test_flush_start_idle;
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_start_stall got %b want 0", stall); end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got %b want 0", busy); end
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic test_flush_wb_done;
        do_op(3'd7, 32'd12345, 32'd77, 1, 1'b1);
        do_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0);
    endtask

    task automatic test_async_reset;
        int cyc;
        start = 1'b1; funct3 = 3'd0; rs1 = 32'd11; rs2 = 32'd13; rd_in = 5'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, stall, valid, result, rd_out} !== '0) begin
            n_fail++; $display("FAIL async_reset busy=%b stall=%b valid=%b result=%h rd=%0d want all 0", busy, stall, valid, result, rd_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
                3: a = 32'h8000_0000;
                default: ;
            endcase
            do_op(f, a, b, int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mulh_variants();
        test_div_signs();
        test_div_special();
        test_flush();
        test_flush_start_idle();
        test_flush_wb_done();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for RV32M multiply/divide operations. The decode stage flags R-type instructions with bit 25 set. For each such instruction, this block accepts the latched operands and runs an iterative shift-add multiply or restoring divide over 32 cycles. It stalls the pipeline until the execute/writeback side accepts the result, and abandons the operation cleanly on a pipeline flush.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- CLK  in  1  pipeline clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request from decode: a valid M-extension instruction is present.
- FUNCT3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- RS1  in  XLEN  operand A; sampled only on the accept edge.
- RS2  in  XLEN  operand B; sampled only on the accept edge.
- RD_IN  in  5  destination register; sampled on the accept edge.
- FLUSH  in  1  synchronous abort.
- WB_ACCEPT  in  1  consumer takes the result this cycle.
- BUSY  out  1  high in every state except IDLE.
- STALL_REQ  out  1  combinational pipeline stall request.
- RESULT_VALID  out  1  RESULT and RD_OUT are valid.
- RESULT  out  XLEN  operation result.
- RD_OUT  out  5  destination register of the result.

## Operation
- States: IDLE, MUL_ITER, DIV_ITER, FIXUP, DONE.
- IDLE transitions:
  - START=1 and FLUSH=0 is an accept edge. The block latches FUNCT3, RD_IN and the operand magnitudes, and records the result sign.
  - Next state is MUL_ITER for FUNCT3[2]=0 and DIV_ITER for FUNCT3[2]=1.
  - Divide special cases go directly to DONE.
- Operand signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: RS1 signed, RS2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- MUL_ITER: 6-bit counter, 32 iterations of unsigned shift-add over the magnitudes into a 64-bit product. Transitions to FIXUP when the count reaches 32.
- DIV_ITER: 32 iterations of restoring division over the magnitudes, producing a 32-bit quotient and a 32-bit remainder. Transitions to FIXUP.
- FIXUP (one cycle) applies signs and selects the result:
  - Multiply: negate the 64-bit product if the operand signs differ. MUL returns bits [31:0]; the MULH variants return bits [63:32].
  - Divide: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - Transition to DONE.
- Divide special cases are resolved at accept and go directly to DONE:
  - Divide by zero: quotient 0xFFFFFFFF; remainder equals RS1 (all divide variants).
  - Signed overflow (DIV/REM with RS1=0x80000000, RS2=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- DONE: RESULT_VALID=1, with RESULT and RD_OUT held stable. WB_ACCEPT=1 at an edge moves the block to IDLE.
- STALL_REQ = (IDLE & START & !FLUSH) | (!IDLE & !(DONE & WB_ACCEPT)).
- FLUSH=1 in any state moves the block to IDLE on the next edge. RESULT_VALID is low from that edge, and no result is produced.
- START while not in IDLE is ignored. Decode holds START under the stall.

## Timing
- Reset values (async): state IDLE, counter 0, BUSY 0, STALL_REQ 0, RESULT_VALID 0, RESULT 0, RD_OUT 0. Reset mid-operation discards the operation immediately.
- Latency, with the accept edge as cycle 0:
  - Iterations occupy cycles 1–32.
  - FIXUP occurs in cycle 33.
  - RESULT_VALID is high from cycle 34.
  - Special cases: RESULT_VALID is high from cycle 1.
- Back-to-back: WB_ACCEPT at edge n gives IDLE in cycle n+1. The earliest next accept is edge n+1, so there is one bubble cycle.
- FLUSH and WB_ACCEPT at the same edge in DONE: both lead to IDLE, and the result counts as consumed.
- FLUSH and START at the same edge in IDLE: not accepted; STALL_REQ=0.
- Input changes on RS1/RS2/FUNCT3 after the accept edge have no effect.

## Test plan
- MUL with RS1=7, RS2=0xFFFFFFFD (−3), accept at cycle 0 -> RESULT_VALID at cycle 34, RESULT=0xFFFFFFEB. With WB_ACCEPT held low for 5 cycles, RESULT stays stable and STALL_REQ stays 1.
- MULH with 0x80000000 × 0x80000000 -> 0x40000000. MULHU with 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Division sign handling:
  - DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIVU 0x1234/0 -> 0xFFFFFFFF at cycle 1.
  - REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- FLUSH asserted at cycle 10 of a DIV -> IDLE and BUSY=0 at cycle 11, RESULT_VALID never asserted. A new MUL accepted at cycle 11 completes correctly at cycle 45.
- RST_N pulsed low asynchronously mid-MUL at cycle 20 -> all outputs 0 immediately. After release, a START is accepted on the first edge.
